// File: rtl/alu_wb_stage_if.sv
// Handshake and data bundle between the ALU and the result/write-back stage.
// master = ALU/producer plus write-back consumer; slave = the stage itself.
interface alu_wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  FS;
  logic [31:0] Y_hi;
  logic [31:0] Y_lo;
  logic        C;
  logic        V;
  logic        N;
  logic        Z;
  logic [1:0]  hilo_sel;
  logic [4:0]  dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_dest;
  logic        out_we;
  logic        out_C;
  logic        out_V;
  logic        out_N;
  logic        out_Z;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  modport master (
    output in_valid, FS, Y_hi, Y_lo, C, V, N, Z, hilo_sel, dest, out_ready,
    input  in_ready, out_valid, out_data, out_dest, out_we, out_C, out_V, out_N, out_Z,
    input  hi_q, lo_q
  );

  modport slave (
    input  in_valid, FS, Y_hi, Y_lo, C, V, N, Z, hilo_sel, dest, out_ready,
    output in_ready, out_valid, out_data, out_dest, out_we, out_C, out_V, out_N, out_Z,
    output hi_q, lo_q
  );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU result / write-back stage: owns HI/LO, resolves MFHI/MFLO and forwards entries
// through a 2-entry skid buffer so in_ready comes straight from a flop.
module alu_wb_stage #(
  parameter logic [4:0] MUL_FS = 5'h1E,
  parameter logic [4:0] DIV_FS = 5'h1F
) (
  input  logic          clk,
  input  logic          reset,
  alu_wb_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        we;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
  } entry_t;

  entry_t      m_q, m_d, k_q, k_d, new_entry;
  logic        m_valid_q, m_valid_d;
  logic        k_valid_q, k_valid_d;
  logic [31:0] hi_val_q, hi_val_d;
  logic [31:0] lo_val_q, lo_val_d;
  logic        accept, emit, is_muldiv;

  assign accept    = bus.in_valid & ~k_valid_q;
  assign emit      = m_valid_q & bus.out_ready;
  assign is_muldiv = (bus.FS == MUL_FS) || (bus.FS == DIV_FS);

  // HI/LO are sampled here, at accept, so a MFHI right behind a MUL sees the new value.
  always_comb begin
    new_entry.data = bus.Y_lo;
    new_entry.dest = bus.dest;
    new_entry.we   = (bus.dest != 5'd0);
    new_entry.c    = bus.C;
    new_entry.v    = bus.V;
    new_entry.n    = bus.N;
    new_entry.z    = bus.Z;
    if (is_muldiv) begin
      new_entry.we = 1'b0;
      new_entry.c  = 1'b0;
      new_entry.v  = 1'b0;
    end else if (bus.hilo_sel == 2'b01) begin
      new_entry.data = hi_val_q;
    end else if (bus.hilo_sel == 2'b10) begin
      new_entry.data = lo_val_q;
    end
  end

  always_comb begin
    m_d       = m_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    k_valid_d = k_valid_q;
    hi_val_d  = hi_val_q;
    lo_val_d  = lo_val_q;

    if (!m_valid_q || emit) begin
      // K non-empty implies in_ready is low, so no accept can collide with the drain.
      if (k_valid_q) begin
        m_d       = k_q;
        m_valid_d = 1'b1;
        k_valid_d = 1'b0;
      end else if (accept) begin
        m_d       = new_entry;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      k_d       = new_entry;
      k_valid_d = 1'b1;
    end

    if (accept && is_muldiv) begin
      hi_val_d = bus.Y_hi;
      lo_val_d = bus.Y_lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q       <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
      hi_val_q  <= '0;
      lo_val_q  <= '0;
    end else begin
      m_q       <= m_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      k_valid_q <= k_valid_d;
      hi_val_q  <= hi_val_d;
      lo_val_q  <= lo_val_d;
    end
  end

  assign bus.in_ready  = ~k_valid_q;
  assign bus.out_valid = m_valid_q;
  assign bus.out_data  = m_q.data;
  assign bus.out_dest  = m_q.dest;
  assign bus.out_we    = m_q.we;
  assign bus.out_C     = m_q.c;
  assign bus.out_V     = m_q.v;
  assign bus.out_N     = m_q.n;
  assign bus.out_Z     = m_q.z;
  assign bus.hi_q      = hi_val_q;
  assign bus.lo_q      = lo_val_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: inputs change and outputs are sampled on the falling edge.
module tb_alu_wb_stage;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_wb_stage_if bus ();

  alu_wb_stage #(
    .MUL_FS(5'h1E),
    .DIV_FS(5'h1F)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] fs, input logic [1:0] sel,
                       input logic [31:0] yhi, input logic [31:0] ylo, input logic [4:0] dst,
                       input logic [3:0] cvnz);
    bus.in_valid = v;
    bus.FS       = fs;
    bus.hilo_sel = sel;
    bus.Y_hi     = yhi;
    bus.Y_lo     = ylo;
    bus.dest     = dst;
    {bus.C, bus.V, bus.N, bus.Z} = cvnz;
  endtask

  task automatic idle();
    drive(1'b0, 5'h00, 2'b00, 32'h0, 32'h0, 5'd0, 4'b0000);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_dest !== 5'd0 || bus.out_we !== 1'b0) begin failures++; $display("FAIL rst_dest_we got=%0d/%b exp=0/0", bus.out_dest, bus.out_we); end
    checks++; if ({bus.out_C, bus.out_V, bus.out_N, bus.out_Z} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {bus.out_C, bus.out_V, bus.out_N, bus.out_Z}); end
    checks++; if (bus.hi_q !== 32'h0 || bus.lo_q !== 32'h0) begin failures++; $display("FAIL rst_hilo got=%h/%h exp=0/0", bus.hi_q, bus.lo_q); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release got=%b/%b exp=0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_pass();
    bus.out_ready = 1'b1;
    drive(1'b1, 5'h04, 2'b00, 32'h0, 32'h0000_0005, 5'd3, 4'b0010);
    @(negedge clk);
    idle();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL pass_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h5) begin failures++; $display("FAIL pass_data got=%h exp=00000005", bus.out_data); end
    checks++; if (bus.out_dest !== 5'd3 || bus.out_we !== 1'b1) begin failures++; $display("FAIL pass_dest_we got=%0d/%b exp=3/1", bus.out_dest, bus.out_we); end
    checks++; if (bus.out_N !== 1'b1 || bus.out_C !== 1'b0) begin failures++; $display("FAIL pass_flags got=N%b C%b exp=N1 C0", bus.out_N, bus.out_C); end
    checks++; if (bus.hi_q !== 32'h0 || bus.lo_q !== 32'h0) begin failures++; $display("FAIL pass_hilo got=%h/%h exp=0/0", bus.hi_q, bus.lo_q); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL pass_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_mul_mfhi_mflo();
    bus.out_ready = 1'b1;
    drive(1'b1, 5'h1E, 2'b00, 32'h0000_0001, 32'hFFFF_FFFE, 5'd5, 4'b1110);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_we !== 1'b0) begin failures++; $display("FAIL mul_valid_we got=%b/%b exp=1/0", bus.out_valid, bus.out_we); end
    checks++; if (bus.out_data !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mul_data got=%h exp=fffffffe", bus.out_data); end
    checks++; if ({bus.out_C, bus.out_V, bus.out_N, bus.out_Z} !== 4'b0010) begin failures++; $display("FAIL mul_flags got=%b exp=0010", {bus.out_C, bus.out_V, bus.out_N, bus.out_Z}); end
    checks++; if (bus.hi_q !== 32'h1 || bus.lo_q !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mul_hilo got=%h/%h exp=00000001/fffffffe", bus.hi_q, bus.lo_q); end
    drive(1'b1, 5'h00, 2'b01, 32'h0, 32'hAAAA_AAAA, 5'd8, 4'b0000);
    @(negedge clk);
    checks++; if (bus.out_data !== 32'h1 || bus.out_dest !== 5'd8 || bus.out_we !== 1'b1) begin failures++; $display("FAIL mfhi got=%h r%0d we%b exp=00000001 r8 we1", bus.out_data, bus.out_dest, bus.out_we); end
    drive(1'b1, 5'h00, 2'b10, 32'h0, 32'h5555_5555, 5'd9, 4'b0000);
    @(negedge clk);
    idle();
    checks++; if (bus.out_data !== 32'hFFFF_FFFE || bus.out_dest !== 5'd9 || bus.out_we !== 1'b1) begin failures++; $display("FAIL mflo got=%h r%0d we%b exp=fffffffe r9 we1", bus.out_data, bus.out_dest, bus.out_we); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mf_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_div();
    bus.out_ready = 1'b1;
    drive(1'b1, 5'h1F, 2'b00, 32'h2, 32'h7, 5'd4, 4'b1101);
    @(negedge clk);
    idle();
    checks++; if (bus.hi_q !== 32'h2 || bus.lo_q !== 32'h7) begin failures++; $display("FAIL div_hilo got=%h/%h exp=00000002/00000007", bus.hi_q, bus.lo_q); end
    checks++; if (bus.out_C !== 1'b0 || bus.out_V !== 1'b0 || bus.out_Z !== 1'b1) begin failures++; $display("FAIL div_flags got=C%b V%b Z%b exp=C0 V0 Z1", bus.out_C, bus.out_V, bus.out_Z); end
    checks++; if (bus.out_we !== 1'b0 || bus.out_data !== 32'h7) begin failures++; $display("FAIL div_we_data got=%b/%h exp=0/00000007", bus.out_we, bus.out_data); end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'h04, 2'b00, 32'h0, 32'h0000_00A1, 5'd1, 4'b0000);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_data !== 32'hA1) begin failures++; $display("FAIL bp_a got=rdy%b %h exp=rdy1 000000a1", bus.in_ready, bus.out_data); end
    drive(1'b1, 5'h04, 2'b00, 32'h0, 32'h0000_00B2, 5'd2, 4'b0000);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", bus.in_ready); end
    drive(1'b1, 5'h04, 2'b00, 32'h0, 32'h0000_00C3, 5'd3, 4'b0000);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA1 || bus.out_dest !== 5'd1) begin failures++; $display("FAIL bp_hold got=v%b %h r%0d exp=v1 000000a1 r1", bus.out_valid, bus.out_data, bus.out_dest); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_held got=%b exp=0", bus.in_ready); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_data !== 32'hB2 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_b got=%h rdy%b exp=000000b2 rdy1", bus.out_data, bus.in_ready); end
    @(negedge clk);
    idle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hC3 || bus.out_dest !== 5'd3) begin failures++; $display("FAIL bp_c got=v%b %h r%0d exp=v1 000000c3 r3", bus.out_valid, bus.out_data, bus.out_dest); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
    checks++; if (bus.hi_q !== 32'h2 || bus.lo_q !== 32'h7) begin failures++; $display("FAIL bp_hilo_kept got=%h/%h exp=00000002/00000007", bus.hi_q, bus.lo_q); end
  endtask

  task automatic test_dest_zero();
    bus.out_ready = 1'b1;
    drive(1'b1, 5'h04, 2'b00, 32'h0, 32'h0000_1234, 5'd0, 4'b0000);
    @(negedge clk);
    idle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_we !== 1'b0 || bus.out_data !== 32'h1234) begin failures++; $display("FAIL dest0 got=v%b we%b %h exp=v1 we0 00001234", bus.out_valid, bus.out_we, bus.out_data); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'h1E, 2'b00, 32'hDEAD_BEEF, 32'h0000_0011, 5'd6, 4'b0000);
    @(negedge clk);
    drive(1'b1, 5'h04, 2'b00, 32'h0, 32'h0000_0022, 5'd7, 4'b0000);
    @(negedge clk);
    idle();
    checks++; if (bus.hi_q !== 32'hDEAD_BEEF || bus.in_ready !== 1'b0) begin failures++; $display("FAIL mr_setup got=%h rdy%b exp=deadbeef rdy0", bus.hi_q, bus.in_ready); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL mr_async got=v%b rdy%b exp=v0 rdy1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.hi_q !== 32'h0 || bus.lo_q !== 32'h0) begin failures++; $display("FAIL mr_hilo got=%h/%h exp=0/0", bus.hi_q, bus.lo_q); end
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mr_no_emit cycle=%0d got=%b exp=0", i, bus.out_valid); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    test_reset();
    test_pass();
    test_mul_mfhi_mflo();
    test_div();
    test_back_pressure();
    test_dest_zero();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Registered result stage directly downstream of the 32-bit ALU. Accepts one ALU result per cycle over a valid/ready handshake and owns the architectural HI/LO registers, updated by MUL/DIV. Resolves MFHI/MFLO reads against them and forwards a write-back word, destination and flags to the register-file stage. A 2-entry skid buffer keeps `in_ready` fully registered, so write-back stalls never create a combinational path back into the ALU.

## Interface
- `MUL_FS`, default 5'h1E: function-select code for multiply; writes HI/LO.
- `DIV_FS`, default 5'h1F: function-select code for divide; writes HI/LO with HI=remainder, LO=quotient.
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: ALU result present this cycle.
- `in_ready`  out  1: stage can accept; registered.
- `FS`  in  5: function select of the result.
- `Y_hi`, `Y_lo`  in  32 each: ALU outputs.
- `C`, `V`, `N`, `Z`  in  1 each: ALU flags.
- `hilo_sel`  in  2: 00 = pass `Y_lo`, 01 = read HI (MFHI), 10 = read LO (MFLO), 11 = pass `Y_lo`.
- `dest`  in  5: destination register number.
- `out_valid`  out  1: write-back entry present.
- `out_ready`  in  1: consumer accepts.
- `out_data`  out  32: write-back word.
- `out_dest`  out  5: destination register.
- `out_we`  out  1: register-file write enable.
- `out_C`, `out_V`, `out_N`, `out_Z`  out  1 each: flags of the entry.
- `hi_q`, `lo_q`  out  32 each: current HI/LO contents.

## Operation
- Accept means `in_valid && in_ready`. Emit means `out_valid && out_ready`.
- Storage is a main output register M, which drives all `out_*` signals, plus a skid register K. Each entry holds data, dest, we and the four flags.
- `in_ready = ~K.valid`.
- Entry formation at accept:
  - If FS = MUL_FS or DIV_FS: data = `Y_lo`, we = 0, C = V = 0, N and Z passed through.
  - If `hilo_sel` = 01: data = `hi_q`. If `hilo_sel` = 10: data = `lo_q`. In both cases, we = 1 if dest != 0, flags are passed through.
  - Otherwise: data = `Y_lo`, we = (dest != 0).
  - Writes to dest = 0 are always suppressed (we = 0), but the entry still flows through.
- HI/LO update: on accept with FS = MUL_FS or DIV_FS, HI <= `Y_hi` and LO <= `Y_lo` on that edge. Any other FS leaves HI/LO unchanged.
- An MFHI/MFLO accepted in cycle n+1 sees HI/LO written by a MUL/DIV accepted in cycle n.
- HI/LO are read at the MFHI/MFLO accept edge, not at emit.
- Buffer transitions (M.valid, K.valid):
  - (0,0) accept -> M loaded.
  - (1,0) emit and accept -> M reloaded. Accept without emit -> K loaded. Emit without accept -> M empties.
  - (1,1) no accept possible. Emit -> M <= K and K empties.
- Ordering is strictly FIFO. The stage never drops or duplicates an entry.
- Reset is asynchronous and may assert mid-operation. All entries are discarded and HI/LO are cleared. There is no partial write-back.

## Timing
- Reset values:
  - `out_valid` = 0, `in_ready` = 1.
  - `out_data` = 0, `out_dest` = 0, `out_we` = 0.
  - All `out_*` flags = 0.
  - `hi_q` = `lo_q` = 0.
- Latency: accept at edge n puts the entry on `out_*` after edge n (visible in cycle n+1) when M was empty or emitting.
- Throughput: 1 entry per cycle while `out_ready` = 1.
- `in_ready` falls in the cycle after a stalled second accept. It rises in the cycle after K drains.
- `out_*` are stable while `out_valid && ~out_ready`.
- `hi_q`/`lo_q` change only on a MUL/DIV accept edge or on reset.

## Test plan
- Reset then pass: accept FS=04, `Y_lo`=32'h0000_0005, dest=3 -> next cycle `out_valid`=1, `out_data`=5, `out_dest`=3, `out_we`=1, `hi_q`=`lo_q`=0.
- MUL then MFHI/MFLO back-to-back: accept FS=1E with `Y_hi`=32'h0000_0001, `Y_lo`=32'hFFFF_FFFE, then `hilo_sel`=01 dest=8, then `hilo_sel`=10 dest=9 -> entries emitted in order:
  - MUL with we=0.
  - 32'h0000_0001 to r8.
  - 32'hFFFF_FFFE to r9.
- DIV: accept FS=1F, `Y_hi`=2 (remainder), `Y_lo`=7 (quotient), with V, C inputs = x -> `hi_q`=2, `lo_q`=7, `out_C`=`out_V`=0, `out_we`=0.
- Back-pressure: hold `out_ready`=0, present 3 valid results A, B, C -> A in M, B in K, `in_ready`=0 and C is held. Raise `out_ready` -> A, B, C emitted on consecutive cycles with none lost.
- dest=0: accept FS=04, `Y_lo`=32'h1234, dest=0 -> `out_valid`=1, `out_we`=0.
- Mid-stream reset: with M and K full and `hi_q`=32'hDEAD_BEEF, assert `reset`=0 asynchronously -> immediately `out_valid`=0, `in_ready`=1, `hi_q`=0. No entry is emitted after release.
